// File: rtl/de_hazard_injector.sv
// Bubble injector in front of the decode/execute buffer: passes decoded fields,
// or substitutes NOP bubbles on a taken branch (flush) or a load-use hazard (stall).
module de_hazard_injector #(
  parameter logic [4:0] NOP_OP       = 5'b00000,
  parameter logic [4:0] LOAD_OP      = 5'b10100,
  parameter int         FLUSH_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        DecST,
  input  logic        DecSST,
  input  logic [16:0] DecReg1,
  input  logic [16:0] DecReg2,
  input  logic [4:0]  DecInstruction,
  input  logic [2:0]  DecSrcAddress,
  input  logic [2:0]  DecRegDestination,
  input  logic        BranchTaken,
  output logic        ST,
  output logic        SST,
  output logic [16:0] Reg1,
  output logic [16:0] Reg2,
  output logic [4:0]  Instruction,
  output logic [2:0]  SrcAddress,
  output logic [2:0]  RegDestination,
  output logic [2:0]  FlashNum,
  output logic        StallFD,
  output logic [1:0]  DbgState
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_N = 3'(FLUSH_CYCLES);

  state_t     r_state;
  logic [2:0] r_flush_cnt;
  logic [4:0] r_last_instr;
  logic [2:0] r_last_dest;

  logic w_flush;
  logic w_hazard;

  assign w_flush  = BranchTaken || (r_state == FLUSH);
  // Only checked in RUN: the bubble issued by a stall clears the last opcode anyway.
  assign w_hazard = (r_last_instr == LOAD_OP) && (r_last_dest == DecSrcAddress) &&
                    (r_state == RUN);
  assign DbgState = r_state;

  always_comb begin
    ST             = 1'b0;
    SST            = 1'b0;
    Reg1           = '0;
    Reg2           = '0;
    Instruction    = NOP_OP;
    SrcAddress     = '0;
    RegDestination = '0;
    StallFD        = 1'b0;
    FlashNum       = '0;
    if (Rst) begin
      if (w_flush) begin
        FlashNum = BranchTaken ? FLUSH_N : r_flush_cnt;
      end else if (w_hazard) begin
        StallFD = 1'b1;
      end else begin
        ST             = DecST;
        SST            = DecSST;
        Reg1           = DecReg1;
        Reg2           = DecReg2;
        Instruction    = DecInstruction;
        SrcAddress     = DecSrcAddress;
        RegDestination = DecRegDestination;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state      <= RUN;
      r_flush_cnt  <= '0;
      r_last_instr <= NOP_OP;
      r_last_dest  <= '0;
    end else begin
      r_last_instr <= Instruction;
      r_last_dest  <= RegDestination;
      if (BranchTaken) begin
        // A branch mid-flush reloads the count rather than extending it.
        if (FLUSH_CYCLES == 1) begin
          r_state     <= RUN;
          r_flush_cnt <= '0;
        end else begin
          r_state     <= FLUSH;
          r_flush_cnt <= FLUSH_N - 3'd1;
        end
      end else begin
        case (r_state)
          FLUSH: begin
            if (r_flush_cnt > 3'd1) begin
              r_flush_cnt <= r_flush_cnt - 3'd1;
            end else begin
              r_state     <= RUN;
              r_flush_cnt <= '0;
            end
          end
          RUN: begin
            if (w_hazard) r_state <= STALL;
          end
          STALL: r_state <= RUN;
          default: begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_de_hazard_injector.sv
// Directed-vector bench for de_hazard_injector: pass-through, flush, load-use stall,
// branch/hazard coincidence, re-branch and asynchronous reset mid-flush.
module tb_de_hazard_injector;

  localparam logic [4:0]  NOP_OP  = 5'b00000;
  localparam logic [4:0]  LOAD_OP = 5'b10100;
  localparam logic [46:0] BUBBLE  = {2'b00, 17'h0, 17'h0, NOP_OP, 3'd0, 3'd0};

  logic        Clk = 1'b0;
  logic        Rst;
  logic        DecST, DecSST, BranchTaken;
  logic [16:0] DecReg1, DecReg2;
  logic [4:0]  DecInstruction;
  logic [2:0]  DecSrcAddress, DecRegDestination;
  logic        ST, SST, StallFD;
  logic [16:0] Reg1, Reg2;
  logic [4:0]  Instruction;
  logic [2:0]  SrcAddress, RegDestination, FlashNum;
  logic [1:0]  DbgState;

  int n_vec  = 0;
  int n_miss = 0;

  de_hazard_injector dut (
    .Clk(Clk), .Rst(Rst),
    .DecST(DecST), .DecSST(DecSST), .DecReg1(DecReg1), .DecReg2(DecReg2),
    .DecInstruction(DecInstruction), .DecSrcAddress(DecSrcAddress),
    .DecRegDestination(DecRegDestination), .BranchTaken(BranchTaken),
    .ST(ST), .SST(SST), .Reg1(Reg1), .Reg2(Reg2), .Instruction(Instruction),
    .SrcAddress(SrcAddress), .RegDestination(RegDestination),
    .FlashNum(FlashNum), .StallFD(StallFD), .DbgState(DbgState)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  logic [46:0] w_out;
  assign w_out = {ST, SST, Reg1, Reg2, Instruction, SrcAddress, RegDestination};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one decode-stage vector just after a posedge; settle before sampling.
  task automatic drive(input logic br, input logic [4:0] instr, input logic [2:0] src,
                       input logic [2:0] dest, input logic [16:0] r1, input logic [16:0] r2,
                       input logic st, input logic sst);
    BranchTaken       = br;
    DecInstruction    = instr;
    DecSrcAddress     = src;
    DecRegDestination = dest;
    DecReg1           = r1;
    DecReg2           = r2;
    DecST             = st;
    DecSST            = sst;
    #4;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic exp_pass(input string tag);
    check({tag, "_out"}, 64'(w_out),
          64'({DecST, DecSST, DecReg1, DecReg2, DecInstruction, DecSrcAddress, DecRegDestination}));
    check({tag, "_stall"}, 64'(StallFD), 64'd0);
    check({tag, "_flash"}, 64'(FlashNum), 64'd0);
  endtask

  task automatic exp_bubble(input string tag, input logic stall, input logic [2:0] flash);
    check({tag, "_out"}, 64'(w_out), 64'(BUBBLE));
    check({tag, "_stall"}, 64'(StallFD), 64'(stall));
    check({tag, "_flash"}, 64'(FlashNum), 64'(flash));
  endtask

  initial begin
    Rst = 1'b0;
    drive(1'b0, 5'h03, 3'd3, 3'd5, 17'h1ABCD, 17'h00042, 1'b1, 1'b1);
    exp_bubble("reset", 1'b0, 3'd0);
    check("reset_state", 64'(DbgState), 64'd0);
    tick();
    Rst = 1'b1;

    // pass-through
    drive(1'b0, 5'h03, 3'd3, 3'd5, 17'h1ABCD, 17'h00042, 1'b1, 1'b0);
    exp_pass("pass");
    tick();

    // flush: two bubbles, FlashNum 2 then 1, then pass
    drive(1'b1, 5'h03, 3'd3, 3'd5, 17'h1ABCD, 17'h00042, 1'b1, 1'b0);
    exp_bubble("flush0", 1'b0, 3'd2);
    tick();
    check("flush_state", 64'(DbgState), 64'd2);
    drive(1'b0, 5'h07, 3'd1, 3'd2, 17'h00111, 17'h00222, 1'b0, 1'b1);
    exp_bubble("flush1", 1'b0, 3'd1);
    tick();
    drive(1'b0, 5'h07, 3'd1, 3'd2, 17'h00111, 17'h00222, 1'b0, 1'b1);
    exp_pass("flush_end");
    tick();

    // load-use: load dest 4, dependent src 4 held two cycles
    drive(1'b0, LOAD_OP, 3'd1, 3'd4, 17'h00010, 17'h00020, 1'b0, 1'b0);
    exp_pass("load");
    tick();
    drive(1'b0, 5'h03, 3'd4, 3'd6, 17'h0BEEF, 17'h10001, 1'b1, 1'b0);
    exp_bubble("stall", 1'b1, 3'd0);
    tick();
    check("stall_state", 64'(DbgState), 64'd1);
    drive(1'b0, 5'h03, 3'd4, 3'd6, 17'h0BEEF, 17'h10001, 1'b1, 1'b0);
    exp_pass("stall_release");
    tick();

    // load followed by independent instruction
    drive(1'b0, LOAD_OP, 3'd0, 3'd4, 17'h00033, 17'h00044, 1'b0, 1'b0);
    exp_pass("load2");
    tick();
    drive(1'b0, 5'h09, 3'd2, 3'd1, 17'h15555, 17'h0AAAA, 1'b0, 1'b1);
    exp_pass("indep");
    tick();

    // hazard coinciding with branch, then re-branch on the last flush cycle
    drive(1'b0, LOAD_OP, 3'd0, 3'd4, 17'h00001, 17'h00002, 1'b0, 1'b0);
    exp_pass("load3");
    tick();
    drive(1'b1, 5'h03, 3'd4, 3'd6, 17'h12345, 17'h06789, 1'b1, 1'b1);
    exp_bubble("coinc", 1'b0, 3'd2);
    tick();
    drive(1'b1, 5'h0A, 3'd3, 3'd3, 17'h00777, 17'h00888, 1'b1, 1'b0);
    exp_bubble("rebranch", 1'b0, 3'd2);
    tick();
    drive(1'b0, 5'h0A, 3'd3, 3'd3, 17'h00777, 17'h00888, 1'b1, 1'b0);
    exp_bubble("rebranch1", 1'b0, 3'd1);
    tick();
    drive(1'b0, 5'h0A, 3'd3, 3'd3, 17'h00777, 17'h00888, 1'b1, 1'b0);
    exp_pass("rebranch_end");
    tick();

    // asynchronous reset mid-flush
    drive(1'b1, 5'h05, 3'd0, 3'd7, 17'h1F0F0, 17'h00F0F, 1'b0, 1'b1);
    exp_bubble("rflush0", 1'b0, 3'd2);
    tick();
    drive(1'b0, 5'h05, 3'd0, 3'd7, 17'h1F0F0, 17'h00F0F, 1'b0, 1'b1);
    exp_bubble("rflush1", 1'b0, 3'd1);
    Rst = 1'b0;
    #1;
    exp_bubble("rst_async", 1'b0, 3'd0);
    check("rst_async_state", 64'(DbgState), 64'd0);
    tick();
    Rst = 1'b1;
    // LastInstr reset to NOP, so src 0 vs LastDest 0 is not a hazard
    drive(1'b0, 5'h05, 3'd0, 3'd7, 17'h1F0F0, 17'h00F0F, 1'b0, 1'b1);
    exp_pass("post_reset");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim time %0t exceeded bound", $time);
    $fatal(1);
  end

endmodule
